// File: rtl/fpga_conf_pkg.sv
// Shared encodings, default sizes and FSM state type for the FPGA config front end.
package fpga_conf_pkg;

  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DATA_W    = 12;
  localparam int unsigned DEF_NUM_REGS  = 4;
  localparam int unsigned DEF_MODE_W    = 3;
  localparam int unsigned DEF_BLANK_CYC = 16;

  // Major-mode encodings; all-ones is OFF
  localparam logic [DEF_MODE_W-1:0] MODE_LF_READ     = 3'd0;
  localparam logic [DEF_MODE_W-1:0] MODE_LF_SIM      = 3'd1;
  localparam logic [DEF_MODE_W-1:0] MODE_HF_READER   = 3'd2;
  localparam logic [DEF_MODE_W-1:0] MODE_HF_SIM      = 3'd3;
  localparam logic [DEF_MODE_W-1:0] MODE_HF_SNOOP    = 3'd4;
  localparam logic [DEF_MODE_W-1:0] MODE_HF_14443A   = 3'd5;
  localparam logic [DEF_MODE_W-1:0] MODE_LF_PASSTHRU = 3'd6;
  localparam logic [DEF_MODE_W-1:0] MODE_OFF         = 3'd7;

  // Error-clear address is all-ones for whatever address width is in use
  function automatic int unsigned errclr_addr(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned ADDR_MODE   = 0;
  localparam int unsigned ADDR_ERRCLR = errclr_addr(DEF_ADDR_W);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BLANK  = 2'd1,
    SWITCH = 2'd2
  } mode_state_e;

endpackage

// File: rtl/conf_spi_rx.sv
// SPI slave receive path in the pck0 domain: synchronisers, edge detect,
// frame shift register and bit counter; emits a registered commit pulse.
module conf_spi_rx
  import fpga_conf_pkg::*;
#(
  parameter int unsigned FRAME_W = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spck,
  input  logic               mosi,
  input  logic               ncs,
  output logic               commit,
  output logic               len_ok,
  output logic [FRAME_W-1:0] frame,
  output logic               ncs_active_c,
  output logic               ncs_fall_c,
  output logic               spck_fall_c
);

  localparam int unsigned CNT_W = $clog2(FRAME_W + 2);

  logic             spck_m, spck_s, spck_d;
  logic             mosi_m, mosi_s;
  logic             ncs_m, ncs_s, ncs_d;
  logic [FRAME_W-1:0] shift;
  logic [CNT_W-1:0]   bit_cnt;
  logic             spck_rise_c, ncs_rise_c;

  assign spck_rise_c  = spck_s & ~spck_d;
  assign spck_fall_c  = ~spck_s & spck_d;
  assign ncs_rise_c   = ncs_s & ~ncs_d;
  assign ncs_fall_c   = ~ncs_s & ncs_d;
  assign ncs_active_c = ~ncs_s;

  // ncs synchroniser idles high so reset never fabricates a select edge
  always_ff @(posedge clk) begin
    if (rst) begin
      spck_m  <= 1'b0;
      spck_s  <= 1'b0;
      spck_d  <= 1'b0;
      mosi_m  <= 1'b0;
      mosi_s  <= 1'b0;
      ncs_m   <= 1'b1;
      ncs_s   <= 1'b1;
      ncs_d   <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
      commit  <= 1'b0;
      len_ok  <= 1'b0;
      frame   <= '0;
    end else begin
      spck_m <= spck;
      spck_s <= spck_m;
      spck_d <= spck_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
      ncs_m  <= ncs;
      ncs_s  <= ncs_m;
      ncs_d  <= ncs_s;
      commit <= 1'b0;
      if (ncs_rise_c) begin
        commit <= 1'b1;
        len_ok <= (bit_cnt == CNT_W'(FRAME_W));
        frame  <= shift;
      end else if (ncs_fall_c) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (spck_rise_c && !ncs_s) begin
        shift <= {shift[FRAME_W-2:0], mosi_s};
        if (bit_cnt != CNT_W'(FRAME_W + 1)) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fpga_conf_regs.sv
// Config front end: SPI frames into NUM_REGS registers plus a blanked major-mode switch.
// Optional SPI readback on miso is enabled by defining CONF_READBACK_EN.
module fpga_conf_regs
  import fpga_conf_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned MODE_W    = DEF_MODE_W,
  parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                       pck0,
  input  logic                       rst,
  input  logic                       spck,
  input  logic                       mosi,
  input  logic                       ncs,
  output logic                       miso,
  output logic [MODE_W-1:0]          major_mode,
  output logic                       mode_blank,
  output logic [NUM_REGS*DATA_W-1:0] conf_regs,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       frame_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(BLANK_CYC + 1);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(ADDR_MODE);
  localparam logic [ADDR_W-1:0] A_CLR  = ADDR_W'(errclr_addr(ADDR_W));

  logic               commit, len_ok;
  logic [FRAME_W-1:0] frame;
  logic               ncs_active_c, ncs_fall_c, spck_fall_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [DATA_W-1:0]  data_c;
  logic               frame_ok_c, mode_req_c;
  logic [MODE_W-1:0]  req_mode_c;

  mode_state_e        state;
  logic [MODE_W-1:0]  pending;
  logic [CNT_W-1:0]   blank_cnt;

  conf_spi_rx #(.FRAME_W(FRAME_W)) u_rx (
    .clk          (pck0),
    .rst          (rst),
    .spck         (spck),
    .mosi         (mosi),
    .ncs          (ncs),
    .commit       (commit),
    .len_ok       (len_ok),
    .frame        (frame),
    .ncs_active_c (ncs_active_c),
    .ncs_fall_c   (ncs_fall_c),
    .spck_fall_c  (spck_fall_c)
  );

  assign addr_c     = frame[FRAME_W-1 -: ADDR_W];
  assign data_c     = frame[DATA_W-1:0];
  assign frame_ok_c = commit & len_ok;
  assign mode_req_c = frame_ok_c && (addr_c == A_MODE);
  assign req_mode_c = data_c[MODE_W-1:0];

  // Register file, write strobes and sticky length error
  always_ff @(posedge pck0) begin
    if (rst) begin
      conf_regs <= '0;
      wr_stb    <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb <= '0;
      if (commit) begin
        if (!len_ok) begin
          frame_err <= 1'b1;
        end else if (addr_c == A_CLR) begin
          frame_err <= 1'b0;
        end else begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_c == ADDR_W'(k + 1)) begin
              conf_regs[k*DATA_W +: DATA_W] <= data_c;
              wr_stb[k]                     <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Mode switch: major_mode only moves inside a blanking window
  always_ff @(posedge pck0) begin
    if (rst) begin
      state      <= RUN;
      major_mode <= '1;
      mode_blank <= 1'b0;
      pending    <= '1;
      blank_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mode_req_c && (req_mode_c != major_mode)) begin
            state      <= BLANK;
            mode_blank <= 1'b1;
            pending    <= req_mode_c;
            blank_cnt  <= CNT_W'(BLANK_CYC - 1);
          end
        end
        BLANK: begin
          if (mode_req_c) begin
            pending   <= req_mode_c;
            blank_cnt <= CNT_W'(BLANK_CYC - 1);
          end else if (blank_cnt == '0) begin
            state      <= SWITCH;
            major_mode <= pending;
          end else begin
            blank_cnt <= blank_cnt - CNT_W'(1);
          end
        end
        SWITCH: begin
          if (mode_req_c && (req_mode_c != major_mode)) begin
            state     <= BLANK;
            pending   <= req_mode_c;
            blank_cnt <= CNT_W'(BLANK_CYC - 1);
          end else begin
            state      <= RUN;
            mode_blank <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          mode_blank <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONF_READBACK_EN
  logic [ADDR_W-1:0]  rb_addr;
  logic [FRAME_W-1:0] tx_sh;
  logic [FRAME_W-1:0] tx_load_c;

  // Readback word for the address of the last accepted frame
  always_comb begin
    tx_load_c = '0;
    if (rb_addr == A_MODE) begin
      tx_load_c              = FRAME_W'(major_mode);
      tx_load_c[FRAME_W-1]   = frame_err;
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rb_addr == ADDR_W'(k + 1)) begin
        tx_load_c = FRAME_W'(conf_regs[k*DATA_W +: DATA_W]);
      end
    end
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      rb_addr <= '0;
      tx_sh   <= '0;
      miso    <= 1'b0;
    end else begin
      if (frame_ok_c) begin
        rb_addr <= addr_c;
      end
      if (!ncs_active_c) begin
        miso <= 1'b0;
      end else if (ncs_fall_c) begin
        tx_sh <= tx_load_c;
        miso  <= tx_load_c[FRAME_W-1];
      end else if (spck_fall_c) begin
        tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
        miso  <= tx_sh[FRAME_W-2];
      end
    end
  end
`else
  logic unused_rb;
  assign unused_rb = ^{ncs_active_c, ncs_fall_c, spck_fall_c};
  assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_conf_regs.sv
// Self-checking bench for fpga_conf_regs: table of register frames with a
// scoreboard queue, plus hand sequences for mode switching, resets and miso.
module tb_fpga_conf_regs;
  import fpga_conf_pkg::*;

  // Long blank window so a complete second frame fits inside it
  localparam int unsigned BLANK_CYC = 100;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned DATA_W    = 12;
  localparam int unsigned MODE_W    = 3;

  logic pck0 = 1'b0;
  logic rst, spck, mosi, ncs;
  logic                       miso;
  logic [MODE_W-1:0]          major_mode;
  logic                       mode_blank;
  logic [NUM_REGS*DATA_W-1:0] conf_regs;
  logic [NUM_REGS-1:0]        wr_stb;
  logic                       frame_err;

  fpga_conf_regs #(
    .ADDR_W(4), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
    .MODE_W(MODE_W), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .pck0       (pck0),
    .rst        (rst),
    .spck       (spck),
    .mosi       (mosi),
    .ncs        (ncs),
    .miso       (miso),
    .major_mode (major_mode),
    .mode_blank (mode_blank),
    .conf_regs  (conf_regs),
    .wr_stb     (wr_stb),
    .frame_err  (frame_err)
  );

  always #5 pck0 = ~pck0;

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic [47:0] regs;
    logic        err;
    logic [3:0]  stb;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Free-running observers; the test takes snapshots and compares deltas
  int blank_total  = 0;
  int glitch_total = 0;
  int mode2_total  = 0;
  int miso_total   = 0;
  int stb_cnt[4]   = '{default: 0};
  logic [MODE_W-1:0] prev_mode = 3'b111;

  always @(negedge pck0) begin
    if (mode_blank) blank_total++;
    if (!rst && !mode_blank && (major_mode !== prev_mode)) glitch_total++;
    prev_mode = major_mode;
    if (major_mode == 3'd2) mode2_total++;
    if (miso) miso_total++;
    for (int k = 0; k < 4; k++) if (wr_stb[k]) stb_cnt[k]++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pck0);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input int half,
                            output logic [31:0] rx);
    rx  = '0;
    ncs = 1'b0;
    tick(half);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      tick(half);
      rx   = {rx[30:0], miso};
      spck = 1'b1;
      tick(half);
      spck = 1'b0;
    end
    tick(half);
    ncs  = 1'b1;
    mosi = 1'b0;
  endtask

  // Waits for major_mode == target; returns cycles since the caller's ncs rise
  task automatic mode_track(input logic [MODE_W-1:0] target, input string tag, output int t_mode);
    t_mode = -1;
    for (int k = 1; k <= int'(BLANK_CYC) + 40; k++) begin
      tick(1);
      if (k == 3) check({tag, " blank before"}, 64'(mode_blank), 64'(1'b1));
      if (k == 4) check({tag, " blank at commit"}, 64'(mode_blank), 64'(1'b1));
      if (major_mode == target && t_mode < 0) t_mode = k;
      if (!mode_blank && k > 4) break;
    end
  endtask

  vec_t        vecs[12];
  vec_t        exp_q[$];
  vec_t        e;
  logic [31:0] rxd;
  int          s0[4];
  int          b0, g0, m0, t_mode;
  logic [15:0] rb_exp;

  initial begin
    vecs[0]  = '{32'h20AB,  16, 48'h000_000_0AB_000, 1'b0, 4'b0010};
    vecs[1]  = '{32'h7FFF,  15, 48'h000_000_0AB_000, 1'b1, 4'b0000};
    vecs[2]  = '{32'h1FFFF, 17, 48'h000_000_0AB_000, 1'b1, 4'b0000};
    vecs[3]  = '{32'hF000,  16, 48'h000_000_0AB_000, 1'b0, 4'b0000};
    vecs[4]  = '{32'h1123,  16, 48'h000_000_0AB_123, 1'b0, 4'b0001};
    vecs[5]  = '{32'h4FFF,  16, 48'hFFF_000_0AB_123, 1'b0, 4'b1000};
    vecs[6]  = '{32'h5123,  16, 48'hFFF_000_0AB_123, 1'b0, 4'b0000};
    vecs[7]  = '{32'hE123,  16, 48'hFFF_000_0AB_123, 1'b0, 4'b0000};
    vecs[8]  = '{32'h0000,  0,  48'hFFF_000_0AB_123, 1'b1, 4'b0000};
    vecs[9]  = '{32'h2555,  16, 48'hFFF_000_555_123, 1'b1, 4'b0010};
    vecs[10] = '{32'hF000,  16, 48'hFFF_000_555_123, 1'b0, 4'b0000};
    vecs[11] = '{32'h3ABC,  16, 48'hFFF_ABC_555_123, 1'b0, 4'b0100};

    rst = 1'b1; ncs = 1'b1; spck = 1'b0; mosi = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("rst conf_regs",  64'(conf_regs),  64'(0));
    check("rst wr_stb",     64'(wr_stb),     64'(0));
    check("rst major_mode", 64'(major_mode), 64'(3'd7));
    check("rst mode_blank", 64'(mode_blank), 64'(0));
    check("rst frame_err",  64'(frame_err),  64'(0));
    check("rst miso",       64'(miso),       64'(0));

    // Mode 3 from OFF
    b0 = blank_total; g0 = glitch_total;
    send_frame(32'h0003, 16, 6, rxd);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      if (k == 3) check("m3 blank pre", 64'(mode_blank), 64'(0));
      if (k == 4) check("m3 blank rise", 64'(mode_blank), 64'(1));
    end
    t_mode = -1;
    for (int k = 5; k <= int'(BLANK_CYC) + 40; k++) begin
      tick(1);
      if (major_mode == 3'd3 && t_mode < 0) t_mode = k;
      if (!mode_blank) break;
    end
    check("m3 latency",   64'(t_mode), 64'(4 + BLANK_CYC));
    check("m3 blank len", 64'(blank_total - b0), 64'(BLANK_CYC + 1));
    check("m3 mode",      64'(major_mode), 64'(3'd3));
    check("m3 glitch",    64'(glitch_total - g0), 64'(0));

    // Request 2, overwritten by request 5 while still blanking
    m0 = mode2_total; g0 = glitch_total;
    send_frame(32'h0002, 16, 6, rxd);
    tick(3);
    send_frame(32'h0005, 16, 2, rxd);
    check("m5 still blank", 64'(mode_blank), 64'(1));
    check("m5 mode held",   64'(major_mode), 64'(3'd3));
    mode_track(3'd5, "m5", t_mode);
    check("m5 latency", 64'(t_mode), 64'(4 + BLANK_CYC));
    check("m5 mode",    64'(major_mode), 64'(3'd5));
    check("m5 no 2",    64'(mode2_total - m0), 64'(0));
    check("m5 glitch",  64'(glitch_total - g0), 64'(0));

    // Same-mode request does not blank
    b0 = blank_total;
    send_frame(32'h0005, 16, 2, rxd);
    tick(10);
    check("same mode blank", 64'(blank_total - b0), 64'(0));

    // Reset in the middle of a blanking window
    send_frame(32'h0001, 16, 2, rxd);
    tick(10);
    check("pre-rst blank", 64'(mode_blank), 64'(1));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst-blank mode",  64'(major_mode), 64'(3'd7));
    check("rst-blank blank", 64'(mode_blank), 64'(0));

    // Register frames through the scoreboard
    for (int i = 0; i < 12; i++) begin
      s0 = stb_cnt;
      send_frame(vecs[i].bits, vecs[i].n, 6, rxd);
      exp_q.push_back(vecs[i]);
      tick(10);
      e = exp_q.pop_front();
      check($sformatf("v%0d regs", i), 64'(conf_regs), 64'(e.regs));
      check($sformatf("v%0d err", i),  64'(frame_err), 64'(e.err));
      for (int k = 0; k < 4; k++)
        check($sformatf("v%0d stb%0d", i, k), 64'(stb_cnt[k] - s0[k]), 64'(e.stb[k]));
    end

`ifdef CONF_READBACK_EN
    rb_exp = 16'h0ABC;
`else
    rb_exp = 16'h0000;
`endif
    send_frame(32'hF000, 16, 6, rxd);
    check("readback reg", 64'(rxd[15:0]), 64'(rb_exp));
    tick(10);
    send_frame(32'hF000, 16, 6, rxd);
    check("readback unmapped", 64'(rxd[15:0]), 64'(0));
    tick(10);
`ifndef CONF_READBACK_EN
    check("miso quiet", 64'(miso_total), 64'(0));
`endif

    // Reset with 8 bits of a frame already shifted
    ncs = 1'b0;
    tick(6);
    for (int i = 7; i >= 0; i--) begin
      mosi = i[0];
      tick(6);
      spck = 1'b1;
      tick(6);
      spck = 1'b0;
    end
    rst = 1'b1; ncs = 1'b1; mosi = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(6);
    send_frame(32'h1123, 16, 6, rxd);
    tick(10);
    check("midrst regs",  64'(conf_regs),  64'(48'h000_000_000_123));
    check("midrst mode",  64'(major_mode), 64'(3'd7));
    check("midrst err",   64'(frame_err),  64'(0));
    check("midrst blank", 64'(mode_blank), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
